// File: rtl/sorter_pkg.sv
// Shared types for the odd-even transposition sorter: FSM state encoding and
// sort direction constants.
package sorter_pkg;
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;
endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-exchange cell: orders (a,b) for the given direction,
// swapping only when strictly out of order so equal keys stay put.
module cmp_swap
  import sorter_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         dir,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swapped
);
  always_comb begin
    swapped = (dir == DIR_DESC) ? (a < b) : (a > b);
    lo      = swapped ? b : a;
    hi      = swapped ? a : b;
  end
endmodule

// File: rtl/oddeven_sorter.sv
// Odd-even transposition sorter: load N words, sort one phase per cycle with
// early exit after two consecutive swap-free phases, then drain in order.
module oddeven_sorter
  import sorter_pkg::*;
#(
  parameter  int N  = 10,
  parameter  int W  = 16,
  localparam int PW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] phases
);
  localparam int NE = N / 2;
  localparam int NO = (N - 1) / 2;
  localparam int NOW = (NO > 0) ? NO : 1;
  localparam logic [PW-1:0] LAST = PW'(N - 1);
  localparam logic [PW-1:0] NMAX = PW'(N);

  state_t r_state, w_state_nx;
  logic [PW-1:0] r_load_idx, r_drain_idx, r_phase, r_phases, w_phase_inc;
  logic r_noswap, r_dir;
  logic [N-1:0][W-1:0] r_mem, w_even, w_odd, w_net;
  logic [NE-1:0]  w_sw_even;
  logic [NOW-1:0] w_sw_odd;
  logic w_any_swap, w_in_fire, w_out_fire, w_load_last, w_drain_last, w_sort_exit;

  // Even phase: pairs (0,1),(2,3)...; a trailing odd element passes through.
  for (genvar k = 0; k < NE; k++) begin : g_even
    cmp_swap #(.W(W)) u_cs (
      .a(r_mem[2*k]), .b(r_mem[2*k+1]), .dir(r_dir),
      .lo(w_even[2*k]), .hi(w_even[2*k+1]), .swapped(w_sw_even[k])
    );
  end
  if (N % 2 == 1) begin : g_even_tail
    assign w_even[N-1] = r_mem[N-1];
  end

  // Odd phase: pairs (1,2),(3,4)...; element 0 and an unpaired last pass through.
  assign w_odd[0] = r_mem[0];
  for (genvar k = 0; k < NO; k++) begin : g_odd
    cmp_swap #(.W(W)) u_cs (
      .a(r_mem[2*k+1]), .b(r_mem[2*k+2]), .dir(r_dir),
      .lo(w_odd[2*k+1]), .hi(w_odd[2*k+2]), .swapped(w_sw_odd[k])
    );
  end
  if (N % 2 == 0) begin : g_odd_tail
    assign w_odd[N-1] = r_mem[N-1];
  end
  if (NO == 0) begin : g_odd_none
    assign w_sw_odd = '0;
  end

  assign w_net        = r_phase[0] ? w_odd : w_even;
  assign w_any_swap   = r_phase[0] ? (|w_sw_odd) : (|w_sw_even);
  assign w_phase_inc  = r_phase + 1'b1;
  assign w_in_fire    = in_valid && in_ready;
  assign w_out_fire   = out_valid && out_ready;
  assign w_load_last  = w_in_fire && (r_load_idx == LAST);
  assign w_drain_last = w_out_fire && (r_drain_idx == LAST);
  assign w_sort_exit  = (r_state == SORT) &&
                        ((w_phase_inc == NMAX) || (!w_any_swap && r_noswap));

  assign in_ready  = (r_state == LOAD);
  assign out_valid = (r_state == DRAIN);
  assign busy      = (r_state == SORT) || (r_state == DRAIN);
  assign done      = w_sort_exit;
  assign phases    = r_phases;

  always_comb begin
    out_data = '0;
    if (r_state == DRAIN)
      for (int i = 0; i < N; i++)
        if (r_drain_idx == PW'(i)) out_data = r_mem[i];
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      LOAD:    if (w_load_last)  w_state_nx = SORT;
      SORT:    if (w_sort_exit)  w_state_nx = DRAIN;
      DRAIN:   if (w_drain_last) w_state_nx = LOAD;
      default: w_state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LOAD;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_idx  <= '0;
      r_drain_idx <= '0;
      r_phase     <= '0;
      r_phases    <= '0;
      r_noswap    <= 1'b0;
      r_dir       <= DIR_ASC;
    end else begin
      if (w_in_fire) r_load_idx <= r_load_idx + 1'b1;
      if (w_load_last) begin
        r_dir    <= dir;
        r_phase  <= '0;
        r_noswap <= 1'b0;
      end
      if (r_state == SORT) begin
        r_phase  <= w_phase_inc;
        r_noswap <= !w_any_swap;
      end
      if (w_sort_exit) begin
        r_phases    <= w_phase_inc;
        r_drain_idx <= '0;
      end
      if (w_out_fire)   r_drain_idx <= r_drain_idx + 1'b1;
      if (w_drain_last) r_load_idx  <= '0;
    end
  end

  // Storage is deliberately unreset; a fresh load overwrites every entry.
  always_ff @(posedge clk) begin
    if (r_state == SORT) r_mem <= w_net;
    else if (w_in_fire)
      for (int i = 0; i < N; i++)
        if (r_load_idx == PW'(i)) r_mem[i] <= in_data;
  end
endmodule

// File: tb/tb_oddeven_sorter.sv
// Bench for oddeven_sorter: table of jobs plus random jobs, scoreboard queue
// of expected drain words, and a reset-during-sort sequence.
module tb_oddeven_sorter;
  localparam int N  = 10;
  localparam int W  = 16;
  localparam int PW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, dir, out_valid, out_ready, busy, done;
  logic [W-1:0]  in_data, out_data;
  logic [PW-1:0] phases;

  oddeven_sorter #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .dir(dir), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .phases(phases)
  );

  always #5 clk = ~clk;

  typedef logic [N-1:0][W-1:0] arr_t;
  typedef struct {
    logic dir;
    arr_t din;
    arr_t dexp;
    int   ph;   // exact phase count, or -1 for range check only
    bit   bp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb[$];
  vec_t tv[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic arr_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
    arr_t r;
    r[0] = W'(a0); r[1] = W'(a1); r[2] = W'(a2); r[3] = W'(a3); r[4] = W'(a4);
    r[5] = W'(a5); r[6] = W'(a6); r[7] = W'(a7); r[8] = W'(a8); r[9] = W'(a9);
    return r;
  endfunction

  function automatic arr_t model(input arr_t d, input logic dsc);
    logic [W-1:0] t;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (dsc ? (d[j] < d[j+1]) : (d[j] > d[j+1])) begin
          t = d[j]; d[j] = d[j+1]; d[j+1] = t;
        end
    return d;
  endfunction

  // Entered and left on a falling edge.
  task automatic run_job(input vec_t v, input string tag);
    int ndone = 0, dcyc = 0, ntx = 0, cyc = 0;
    logic stalled = 1'b0;
    logic [W-1:0] held = '0, expw;
    while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = v.din[i]; dir = v.dir;
      sb.push_back(v.dexp[i]);
      @(negedge clk);
    end
    dir = ~v.dir;  // only the value at the last transfer may matter
    chk({tag, "_sort_busy"}, {in_ready, busy}, 32'b01);
    cyc = 1;
    while (ntx < N && cyc < 300) begin
      if (done) begin ndone++; dcyc = cyc; end
      if (out_valid) begin
        if (stalled) chk({tag, "_hold"}, 32'(out_data), 32'(held));
        out_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) begin
          if (ntx == N - 1) chk({tag, "_last_no_ready"}, 32'(in_ready), 32'd0);
          expw = sb.pop_front();
          chk($sformatf("%s_data%0d", tag, ntx), 32'(out_data), 32'(expw));
          ntx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = out_data;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    if (ntx < N) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=%0d transfers required=%0d", tag, ntx, N);
      sb.delete();
    end
    chk({tag, "_after_drain"}, {in_ready, out_valid, busy}, 32'b100);
    chk({tag, "_done_count"}, 32'(ndone), 32'd1);
    chk({tag, "_done_time"}, 32'(dcyc), 32'(phases));
    if (v.ph >= 0) chk({tag, "_phases"}, 32'(phases), 32'(v.ph));
    else chk({tag, "_phases_range"}, 32'(phases >= 2 && phases <= N), 32'd1);
  endtask

  initial begin
    vec_t rv;
    int sawbad;
    in_valid = 1'b0; out_ready = 1'b0; dir = 1'b0; in_data = '0;
    reset = 1'b1;
    #2;
    chk("reset_outputs", {in_ready, out_valid, busy, done}, 32'b1000);
    chk("reset_phases", 32'(phases), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    tv[0] = '{1'b0, mk(9,3,7,1,8,2,6,0,5,4), mk(0,1,2,3,4,5,6,7,8,9), -1, 1'b0};
    tv[1] = '{1'b1, mk(0,1,2,3,4,5,6,7,8,9), mk(9,8,7,6,5,4,3,2,1,0), 10, 1'b0};
    tv[2] = '{1'b0, mk(0,1,2,3,4,5,6,7,8,9), mk(0,1,2,3,4,5,6,7,8,9), 2, 1'b0};
    tv[3] = '{1'b0, mk(5,5,1,1,16'hFFFF,0,5,1,0,16'hFFFF),
                    mk(0,0,1,1,1,5,5,5,16'hFFFF,16'hFFFF), -1, 1'b0};
    tv[4] = '{1'b1, mk(9,3,7,1,8,2,6,0,5,4), mk(9,8,7,6,5,4,3,2,1,0), -1, 1'b1};
    tv[5] = '{1'b1, mk(9,8,7,6,5,4,3,2,1,0), mk(9,8,7,6,5,4,3,2,1,0), 2, 1'b1};

    for (int t = 0; t < 6; t++) run_job(tv[t], $sformatf("vec%0d", t));

    for (int r = 0; r < 3; r++) begin
      rv.dir = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++)
        rv.din[i] = (r == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      rv.dexp = model(rv.din, rv.dir);
      rv.ph = -1;
      rv.bp = 1'b1;
      run_job(rv, $sformatf("rand%0d", r));
    end

    // Reset in the middle of SORT abandons the job.
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = tv[1].din[i]; dir = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_sort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_sort_reset_outs", {in_ready, out_valid, busy, done}, 32'b1000);
    chk("mid_sort_reset_phases", 32'(phases), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sawbad = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = 1'b1;
      if (done || out_valid || busy || !in_ready) sawbad++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("after_reset_idle", 32'(sawbad), 32'd0);
    run_job(tv[0], "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
